// File: rtl/execute_stage_if.sv
// Decode-to-execute input bundle, stall/flush controls, and the EX/MEM register outputs.
// The master side drives the instruction in; the slave side is the execute stage.
interface execute_stage_if;
  logic        wb_branch_hazard;
  logic        stall_flg;
  logic [31:0] input_reg_pc;
  logic [4:0]  input_exe_fun;
  logic [31:0] input_op1_data;
  logic [31:0] input_op2_data;
  logic [31:0] input_rs2_data;
  logic [3:0]  input_mem_wen;
  logic        input_rf_wen;
  logic [3:0]  input_wb_sel;
  logic [4:0]  input_wb_addr;
  logic [2:0]  input_csr_cmd;
  logic        input_jmp_flg;
  logic [31:0] input_imm_i_sext;
  logic [31:0] input_imm_b_sext;
  logic        input_inst_is_ecall;

  logic [31:0] alu_out;
  logic        br_flg;
  logic [31:0] br_target;
  logic [31:0] output_reg_pc;
  logic [3:0]  output_mem_wen;
  logic        output_rf_wen;
  logic [31:0] output_rs2_data;
  logic [3:0]  output_wb_sel;
  logic [4:0]  output_wb_addr;
  logic [2:0]  output_csr_cmd;
  logic        output_jmp_flg;
  logic        output_inst_is_ecall;
  logic [31:0] output_op1_data;
  logic [31:0] output_imm_i;

  modport master (
    output wb_branch_hazard, stall_flg, input_reg_pc, input_exe_fun, input_op1_data,
           input_op2_data, input_rs2_data, input_mem_wen, input_rf_wen, input_wb_sel,
           input_wb_addr, input_csr_cmd, input_jmp_flg, input_imm_i_sext,
           input_imm_b_sext, input_inst_is_ecall,
    input  alu_out, br_flg, br_target, output_reg_pc, output_mem_wen, output_rf_wen,
           output_rs2_data, output_wb_sel, output_wb_addr, output_csr_cmd, output_jmp_flg,
           output_inst_is_ecall, output_op1_data, output_imm_i
  );

  modport slave (
    input  wb_branch_hazard, stall_flg, input_reg_pc, input_exe_fun, input_op1_data,
           input_op2_data, input_rs2_data, input_mem_wen, input_rf_wen, input_wb_sel,
           input_wb_addr, input_csr_cmd, input_jmp_flg, input_imm_i_sext,
           input_imm_b_sext, input_inst_is_ecall,
    output alu_out, br_flg, br_target, output_reg_pc, output_mem_wen, output_rf_wen,
           output_rs2_data, output_wb_sel, output_wb_addr, output_csr_cmd, output_jmp_flg,
           output_inst_is_ecall, output_op1_data, output_imm_i
  );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: ALU, branch compare and target, registered into EX/MEM.
// Flush turns the slot into a bubble (controls zeroed) and overrides a stall.
module execute_stage (
  input logic        clk,
  input logic        rst,
  execute_stage_if.slave ex
);
  typedef enum logic [4:0] {
    FUN_X    = 5'd0,  FUN_ADD  = 5'd1,  FUN_SUB  = 5'd2,  FUN_AND  = 5'd3,
    FUN_OR   = 5'd4,  FUN_XOR  = 5'd5,  FUN_SLL  = 5'd6,  FUN_SRL  = 5'd7,
    FUN_SRA  = 5'd8,  FUN_SLT  = 5'd9,  FUN_SLTU = 5'd10, FUN_BEQ  = 5'd11,
    FUN_BNE  = 5'd12, FUN_BLT  = 5'd13, FUN_BGE  = 5'd14, FUN_BLTU = 5'd15,
    FUN_BGEU = 5'd16, FUN_JALR = 5'd17, FUN_COPY1 = 5'd18
  } exe_fun_e;

  typedef struct packed {
    logic [31:0] alu;
    logic        br;
    logic [31:0] target;
    logic [31:0] pc;
    logic [3:0]  mem_wen;
    logic        rf_wen;
    logic [31:0] rs2;
    logic [3:0]  wb_sel;
    logic [4:0]  wb_addr;
    logic [2:0]  csr_cmd;
    logic        jmp;
    logic        ecall;
    logic [31:0] op1;
    logic [31:0] imm_i;
  } ex_mem_t;

  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  shamt;
  logic [31:0] sum;
  logic        lt_signed;
  logic        lt_unsigned;
  logic [31:0] alu_res;
  logic        br_res;
  exe_fun_e    fun;

  ex_mem_t ex_mem_d;
  ex_mem_t ex_mem_q;

  assign op1         = ex.input_op1_data;
  assign op2         = ex.input_op2_data;
  assign shamt       = op2[4:0];
  assign sum         = op1 + op2;
  assign lt_signed   = $signed(op1) < $signed(op2);
  assign lt_unsigned = op1 < op2;
  assign fun         = exe_fun_e'(ex.input_exe_fun);

  always_comb begin
    alu_res = '0;
    br_res  = 1'b0;
    case (fun)
      FUN_ADD:   alu_res = sum;
      FUN_SUB:   alu_res = op1 - op2;
      FUN_AND:   alu_res = op1 & op2;
      FUN_OR:    alu_res = op1 | op2;
      FUN_XOR:   alu_res = op1 ^ op2;
      FUN_SLL:   alu_res = op1 << shamt;
      FUN_SRL:   alu_res = op1 >> shamt;
      FUN_SRA:   alu_res = $unsigned($signed(op1) >>> shamt);
      FUN_SLT:   alu_res = {31'd0, lt_signed};
      FUN_SLTU:  alu_res = {31'd0, lt_unsigned};
      FUN_BEQ:   br_res  = (op1 == op2);
      FUN_BNE:   br_res  = (op1 != op2);
      FUN_BLT:   br_res  = lt_signed;
      FUN_BGE:   br_res  = !lt_signed;
      FUN_BLTU:  br_res  = lt_unsigned;
      FUN_BGEU:  br_res  = !lt_unsigned;
      FUN_JALR:  alu_res = sum & 32'hFFFF_FFFE;
      FUN_COPY1: alu_res = op1;
      default: begin
        alu_res = '0;
        br_res  = 1'b0;
      end
    endcase
  end

  always_comb begin
    ex_mem_d = ex_mem_q;
    // A flush must still land even while memory is stalling, or the squashed op would linger.
    if (ex.wb_branch_hazard || !ex.stall_flg) begin
      ex_mem_d.alu     = alu_res;
      ex_mem_d.br      = br_res;
      ex_mem_d.target  = ex.input_reg_pc + ex.input_imm_b_sext;
      ex_mem_d.pc      = ex.input_reg_pc;
      ex_mem_d.mem_wen = ex.input_mem_wen;
      ex_mem_d.rf_wen  = ex.input_rf_wen;
      ex_mem_d.rs2     = ex.input_rs2_data;
      ex_mem_d.wb_sel  = ex.input_wb_sel;
      ex_mem_d.wb_addr = ex.input_wb_addr;
      ex_mem_d.csr_cmd = ex.input_csr_cmd;
      ex_mem_d.jmp     = ex.input_jmp_flg;
      ex_mem_d.ecall   = ex.input_inst_is_ecall;
      ex_mem_d.op1     = ex.input_op1_data;
      ex_mem_d.imm_i   = ex.input_imm_i_sext;
      if (ex.wb_branch_hazard) begin
        ex_mem_d.br      = 1'b0;
        ex_mem_d.mem_wen = '0;
        ex_mem_d.rf_wen  = 1'b0;
        ex_mem_d.wb_sel  = '0;
        ex_mem_d.csr_cmd = '0;
        ex_mem_d.jmp     = 1'b0;
        ex_mem_d.ecall   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign ex.alu_out              = ex_mem_q.alu;
  assign ex.br_flg               = ex_mem_q.br;
  assign ex.br_target            = ex_mem_q.target;
  assign ex.output_reg_pc        = ex_mem_q.pc;
  assign ex.output_mem_wen       = ex_mem_q.mem_wen;
  assign ex.output_rf_wen        = ex_mem_q.rf_wen;
  assign ex.output_rs2_data      = ex_mem_q.rs2;
  assign ex.output_wb_sel        = ex_mem_q.wb_sel;
  assign ex.output_wb_addr       = ex_mem_q.wb_addr;
  assign ex.output_csr_cmd       = ex_mem_q.csr_cmd;
  assign ex.output_jmp_flg       = ex_mem_q.jmp;
  assign ex.output_inst_is_ecall = ex_mem_q.ecall;
  assign ex.output_op1_data      = ex_mem_q.op1;
  assign ex.output_imm_i         = ex_mem_q.imm_i;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the EX/MEM register.
module tb_execute_stage;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;

  execute_stage_if ifc ();

  execute_stage dut (
    .clk (clk),
    .rst (rst),
    .ex  (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] alu;
    logic        br;
    logic [31:0] target;
    logic [31:0] pc;
    logic [3:0]  mem_wen;
    logic        rf_wen;
    logic [31:0] rs2;
    logic [3:0]  wb_sel;
    logic [4:0]  wb_addr;
    logic [2:0]  csr_cmd;
    logic        jmp;
    logic        ecall;
    logic [31:0] op1;
    logic [31:0] imm_i;
  } outs_t;

  outs_t exp_s;

  function automatic outs_t observed();
    outs_t o;
    o.alu     = ifc.alu_out;
    o.br      = ifc.br_flg;
    o.target  = ifc.br_target;
    o.pc      = ifc.output_reg_pc;
    o.mem_wen = ifc.output_mem_wen;
    o.rf_wen  = ifc.output_rf_wen;
    o.rs2     = ifc.output_rs2_data;
    o.wb_sel  = ifc.output_wb_sel;
    o.wb_addr = ifc.output_wb_addr;
    o.csr_cmd = ifc.output_csr_cmd;
    o.jmp     = ifc.output_jmp_flg;
    o.ecall   = ifc.output_inst_is_ecall;
    o.op1     = ifc.output_op1_data;
    o.imm_i   = ifc.output_imm_i;
    return o;
  endfunction

  // Reference ALU: plain arithmetic per function code.
  function automatic logic [31:0] ref_alu(input int f, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [31:0] r;
    sh = int'(b % 32);
    case (f)
      1:  r = a + b;
      2:  r = a + (~b + 32'd1);
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = 32'(longint'(a) * (64'd1 << sh));
      7:  r = 32'(longint'(a) / (64'd1 << sh));
      8:  r = (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      9:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      10: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      17: r = (a + b) & 32'hFFFF_FFFE;
      18: r = a;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic ref_br(input int f, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    case (f)
      11: return a == b;
      12: return a != b;
      13: return sa < sb;
      14: return sa >= sb;
      15: return longint'(a) < longint'(b);
      16: return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  // Next register contents given the current inputs and the previous contents.
  function automatic outs_t model_next(input outs_t prev);
    outs_t n;
    if (ifc.stall_flg && !ifc.wb_branch_hazard) return prev;
    n.alu     = ref_alu(int'(ifc.input_exe_fun), ifc.input_op1_data, ifc.input_op2_data);
    n.br      = ref_br(int'(ifc.input_exe_fun), ifc.input_op1_data, ifc.input_op2_data);
    n.target  = ifc.input_reg_pc + ifc.input_imm_b_sext;
    n.pc      = ifc.input_reg_pc;
    n.mem_wen = ifc.input_mem_wen;
    n.rf_wen  = ifc.input_rf_wen;
    n.rs2     = ifc.input_rs2_data;
    n.wb_sel  = ifc.input_wb_sel;
    n.wb_addr = ifc.input_wb_addr;
    n.csr_cmd = ifc.input_csr_cmd;
    n.jmp     = ifc.input_jmp_flg;
    n.ecall   = ifc.input_inst_is_ecall;
    n.op1     = ifc.input_op1_data;
    n.imm_i   = ifc.input_imm_i_sext;
    if (ifc.wb_branch_hazard) begin
      n.br = 1'b0; n.mem_wen = '0; n.rf_wen = 1'b0; n.wb_sel = '0;
      n.csr_cmd = '0; n.jmp = 1'b0; n.ecall = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic set_random();
    ifc.input_reg_pc        = $urandom;
    ifc.input_exe_fun       = 5'($urandom_range(0, 31));
    ifc.input_op1_data      = pick_operand();
    ifc.input_op2_data      = pick_operand();
    ifc.input_rs2_data      = $urandom;
    ifc.input_mem_wen       = 4'($urandom);
    ifc.input_rf_wen        = 1'($urandom);
    ifc.input_wb_sel        = 4'($urandom);
    ifc.input_wb_addr       = 5'($urandom);
    ifc.input_csr_cmd       = 3'($urandom);
    ifc.input_jmp_flg       = 1'($urandom);
    ifc.input_imm_i_sext    = $urandom;
    ifc.input_imm_b_sext    = $urandom;
    ifc.input_inst_is_ecall = 1'($urandom);
  endtask

  task automatic set_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    ifc.input_exe_fun  = f;
    ifc.input_op1_data = a;
    ifc.input_op2_data = b;
  endtask

  // One clock: update model from inputs at the edge, then sample 1 ns later.
  task automatic cycle();
    outs_t n;
    n = model_next(exp_s);
    @(posedge clk);
    #1;
    exp_s = n;
    cyc++;
    $display("txn %0d fun=%0d op1=%h op2=%h haz=%0b stall=%0b -> alu=%h br=%0b tgt=%h",
             cyc, ifc.input_exe_fun, ifc.input_op1_data, ifc.input_op2_data,
             ifc.wb_branch_hazard, ifc.stall_flg, ifc.alu_out, ifc.br_flg, ifc.br_target);
  endtask

  task automatic test_reset();
    outs_t o;
    rst = 1'b1;
    ifc.wb_branch_hazard = 1'b0;
    ifc.stall_flg = 1'b0;
    set_random();
    #12;
    checks++;
    o = observed();
    if (o !== '0) begin
      failures++;
      $display("FAIL reset_initial got=%h exp=0", o);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_s = '0;
    set_random();
    ifc.input_rf_wen = 1'b1;
    set_op(5'd1, 32'h10, 32'h20);
    cycle();
    checks++;
    if (ifc.alu_out !== 32'h30 || ifc.output_rf_wen !== 1'b1) begin
      failures++;
      $display("FAIL reset_preload got alu=%h rf=%b exp alu=00000030 rf=1", ifc.alu_out, ifc.output_rf_wen);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    o = observed();
    if (o !== '0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0", o);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_s = '0;
  endtask

  task automatic test_alu();
    logic [4:0]  f[5]   = '{5'd1, 5'd8, 5'd9, 5'd10, 5'd17};
    logic [31:0] a[5]   = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1001};
    logic [31:0] b[5]   = '{32'd2, 32'h24, 32'd1, 32'd1, 32'd2};
    logic [31:0] res[5] = '{32'd1, 32'hF800_0000, 32'd1, 32'd0, 32'h1002};
    ifc.wb_branch_hazard = 1'b0;
    ifc.stall_flg = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_random();
      set_op(f[i], a[i], b[i]);
      cycle();
      checks++;
      if (ifc.alu_out !== res[i]) begin
        failures++;
        $display("FAIL alu_fun%0d got=%h exp=%h", f[i], ifc.alu_out, res[i]);
      end
    end
  endtask

  task automatic test_branch();
    ifc.wb_branch_hazard = 1'b0;
    ifc.stall_flg = 1'b0;
    set_random();
    set_op(5'd13, 32'hFFFF_FFFE, 32'd1);
    ifc.input_reg_pc = 32'h100;
    ifc.input_imm_b_sext = 32'hFFFF_FFF0;
    cycle();
    checks++;
    if (ifc.br_flg !== 1'b1 || ifc.br_target !== 32'hF0 || ifc.alu_out !== 32'd0) begin
      failures++;
      $display("FAIL branch_blt got br=%b tgt=%h alu=%h exp br=1 tgt=000000f0 alu=0",
               ifc.br_flg, ifc.br_target, ifc.alu_out);
    end
    ifc.input_exe_fun = 5'd15;
    cycle();
    checks++;
    if (ifc.br_flg !== 1'b0 || ifc.br_target !== 32'hF0) begin
      failures++;
      $display("FAIL branch_bltu got br=%b tgt=%h exp br=0 tgt=000000f0", ifc.br_flg, ifc.br_target);
    end
  endtask

  task automatic test_random_alu();
    outs_t o;
    ifc.wb_branch_hazard = 1'b0;
    ifc.stall_flg = 1'b0;
    for (int i = 0; i < 80; i++) begin
      set_random();
      cycle();
      checks++;
      o = observed();
      if (o !== exp_s) begin
        failures++;
        $display("FAIL random_alu cycle=%0d got=%h exp=%h", cyc, o, exp_s);
      end
    end
  endtask

  task automatic test_stall();
    outs_t held;
    outs_t o;
    ifc.wb_branch_hazard = 1'b0;
    ifc.stall_flg = 1'b0;
    set_random();
    set_op(5'd1, 32'd3, 32'd4);
    cycle();
    checks++;
    if (ifc.alu_out !== 32'd7) begin
      failures++;
      $display("FAIL stall_load got=%h exp=00000007", ifc.alu_out);
    end
    held = exp_s;
    ifc.stall_flg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_random();
      set_op(5'd2, 32'd100, 32'd1);
      cycle();
      checks++;
      o = observed();
      if (o !== held || ifc.alu_out !== 32'd7) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d got=%h exp=%h", cyc, o, held);
      end
    end
    ifc.stall_flg = 1'b0;
    cycle();
    checks++;
    o = observed();
    if (o !== exp_s || ifc.alu_out !== 32'd99) begin
      failures++;
      $display("FAIL stall_release got=%h exp=%h", o, exp_s);
    end
  endtask

  task automatic test_flush();
    outs_t o;
    set_random();
    ifc.input_rf_wen = 1'b1;
    ifc.input_mem_wen = 4'd1;
    ifc.input_jmp_flg = 1'b1;
    ifc.input_inst_is_ecall = 1'b1;
    ifc.input_csr_cmd = 3'd5;
    ifc.input_wb_sel = 4'd3;
    ifc.input_reg_pc = 32'h200;
    set_op(5'd11, 32'h55, 32'h55);
    ifc.wb_branch_hazard = 1'b1;
    ifc.stall_flg = 1'b1;
    cycle();
    checks++;
    if ({ifc.output_rf_wen, ifc.output_mem_wen, ifc.output_jmp_flg, ifc.output_inst_is_ecall,
         ifc.br_flg, ifc.output_csr_cmd, ifc.output_wb_sel} !== 15'd0) begin
      failures++;
      $display("FAIL flush_ctrl got rf=%b mem=%h jmp=%b ecall=%b br=%b csr=%h wbsel=%h exp all 0",
               ifc.output_rf_wen, ifc.output_mem_wen, ifc.output_jmp_flg, ifc.output_inst_is_ecall,
               ifc.br_flg, ifc.output_csr_cmd, ifc.output_wb_sel);
    end
    checks++;
    if (ifc.output_reg_pc !== 32'h200 || ifc.output_op1_data !== 32'h55) begin
      failures++;
      $display("FAIL flush_data got pc=%h op1=%h exp pc=00000200 op1=00000055",
               ifc.output_reg_pc, ifc.output_op1_data);
    end
    checks++;
    o = observed();
    if (o !== exp_s) begin
      failures++;
      $display("FAIL flush_model got=%h exp=%h", o, exp_s);
    end
    ifc.wb_branch_hazard = 1'b0;
    ifc.stall_flg = 1'b0;
  endtask

  task automatic test_back_to_back();
    outs_t o;
    for (int i = 0; i < 120; i++) begin
      set_random();
      ifc.stall_flg = ($urandom_range(0, 3) == 0);
      ifc.wb_branch_hazard = ($urandom_range(0, 5) == 0);
      cycle();
      checks++;
      o = observed();
      if (o !== exp_s) begin
        failures++;
        $display("FAIL back_to_back cycle=%0d got=%h exp=%h", cyc, o, exp_s);
      end
      checks++;
      if (ifc.output_imm_i !== exp_s.imm_i || ifc.output_op1_data !== exp_s.op1) begin
        failures++;
        $display("FAIL passthrough_imm_op1 cycle=%0d got imm=%h op1=%h exp imm=%h op1=%h",
                 cyc, ifc.output_imm_i, ifc.output_op1_data, exp_s.imm_i, exp_s.op1);
      end
    end
    ifc.stall_flg = 1'b0;
    ifc.wb_branch_hazard = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    exp_s = '0;
    test_reset();
    test_alu();
    test_branch();
    test_random_alu();
    test_stall();
    test_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
